run_length_encoder: RTL and testbench
=====================================

// Module: run_length_encoder
// PURPOSE
//  Run-length encoder: the transmit-side counterpart of the run-length decoder (rd_out/ready).
//  Compresses a byte stream into (data, count) pairs, each pair stating one byte value and its repeat count.
//  Pairs drive the decoder's data_din/data_cin inputs through a valid/ready handshake.
//  Sits between the byte source and the pair link; one pair in flight at a time.
// PARAMETERS
//  DATA_W  8  width of a symbol (data_din / data_dout)
//  CNT_W   4  width of the repeat count; MAX_RUN = 2**CNT_W-1 (15); count 0 is never emitted
// PORTS
//  CLK         in   1       clock, all logic on rising edge
//  RST_N       in   1       reset, asynchronous assert, active-low
//  din_valid   in   1       input byte valid
//  din         in   DATA_W  input byte
//  din_last    in   1       byte is the final one of the message; closes the open run
//  din_ready   out  1       encoder accepts din this cycle (transfer = din_valid & din_ready)
//  dout_valid  out  1       pair valid
//  data_dout   out  DATA_W  run symbol
//  data_cout   out  CNT_W   run length, 1..MAX_RUN
//  dout_last   out  1       pair is the final one of the message
//  dout_ready  in   1       downstream accepts pair (transfer = dout_valid & dout_ready)
// BEHAVIOUR
//  Reset (RST_N=0, async): state=IDLE, run_sym=0, run_cnt=0, dout_valid=0, data_dout=0, data_cout=0,
//   dout_last=0; din_ready forced 0 while RST_N=0.
//  Output register: one deep; out_free = !dout_valid | dout_ready. Pair fields are stable while dout_valid=1 & dout_ready=0.
//  din_ready = RST_N & (state!=FLUSH) & out_free (combinational).
//  FSM states IDLE, RUN, FLUSH:
//   IDLE: accepted byte b -> run_sym=b, run_cnt=1, -> RUN. If din_last also set: emit (b,1,last), stay IDLE.
//   RUN, accepted b==run_sym & run_cnt<MAX_RUN: run_cnt++; if din_last: emit (run_sym,run_cnt+1,last) -> IDLE.
//   RUN, accepted b!=run_sym or run_cnt==MAX_RUN: emit (run_sym,run_cnt,0); run_sym=b, run_cnt=1;
//    if din_last -> FLUSH, else stay RUN.
//   FLUSH: din_ready=0; when out_free, emit (run_sym,1,last) -> IDLE.
//  Emit = load output register, dout_valid=1 next cycle; latency: pair visible 1 cycle after closing byte accepted.
//  Output register clears dout_valid on transfer unless reloaded the same cycle (back-to-back pairs allowed).
//  No emit without an accepted byte or FLUSH; an open run with no din_last is held indefinitely.
//  Saturation: 16th equal byte closes a 15-run and opens a new run of 1; counter never wraps to 0.
//  din accepted while out register stalled is impossible (din_ready low), so no pair is ever dropped.
//  Reset mid-run: open run and pending pair are discarded; no partial pair is emitted after release.
// CONFIGURATION
//  RLE_STATS_EN defined: adds outputs stat_bytes[15:0] (bytes accepted) and stat_pairs[15:0] (pairs
//   transferred), both reset 0, wrap at 2^16; ratio readable by debug logic.
//  RLE_STATS_EN undefined: ports and counters absent; core behaviour identical.
// STRUCTURE
//  Package rle_pkg: state enum (IDLE/RUN/FLUSH), default DATA_W/CNT_W, MAX_RUN function.
//  Sub-module rle_out_reg: one-deep valid/ready holding register for {data, count, last}; FSM in top.
// TESTING
//  100,100 | 97x3 | 98,98 | 99x4 (last on final) with dout_ready=1 -> (100,2),(97,3),(98,2),(99,4,last).
//  17 x 0x41, last on 17th -> (0x41,15,0),(0x41,2,last); data_cout never 0.
//  Single byte 0x55 with last from IDLE -> (0x55,1,last) one cycle later; state back to IDLE.
//  7,7,9(last) -> (7,2,0) then FLUSH with din_ready=0 -> (9,1,last).
//  dout_ready=0 for 5 cycles mid-stream -> din_ready=0, pair fields stable, no bytes lost or merged.
//  RST_N pulsed low during a 5-byte run -> outputs zero immediately; next stream 3,3(last) -> (3,2,last) only.

Source files
------------

// File: rtl/rle_pkg.sv
// Shared types and sizing helpers for the run-length encoder.
// Optional statistics outputs are enabled with the RLE_STATS_EN macro.
package rle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } rle_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 4;

    // Longest run a single pair can describe; count 0 is never used.
    function automatic int max_run(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/rle_out_reg.sv
// One-deep valid/ready holding register for a {data, count, last} pair.
// Fields hold steady while the pair waits for the consumer.
module rle_out_reg
    import rle_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CNT_W-1:0]  i_cnt,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_cnt,
    output logic              o_last,
    output logic              o_free
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_last;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_cnt   <= i_cnt;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_cnt   = r_cnt;
    assign o_last  = r_last;
    assign o_free  = !r_valid || i_ready;

endmodule

// File: rtl/run_length_encoder.sv
// Run-length encoder: folds a byte stream into (symbol, count) pairs on a valid/ready link.
// Define RLE_STATS_EN to add stat_bytes / stat_pairs debug counters.
module run_length_encoder
    import rle_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              din_valid,
    input  logic [DATA_W-1:0] din,
    input  logic              din_last,
    output logic              din_ready,
    output logic              dout_valid,
    output logic [DATA_W-1:0] data_dout,
    output logic [CNT_W-1:0]  data_cout,
    output logic              dout_last,
    input  logic              dout_ready
`ifdef RLE_STATS_EN
   ,output logic [15:0]       stat_bytes,
    output logic [15:0]       stat_pairs
`endif
);

    localparam logic [CNT_W-1:0] MAX_RUN = CNT_W'(max_run(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    rle_state_t        r_state;
    logic [DATA_W-1:0] r_run_sym;
    logic [CNT_W-1:0]  r_run_cnt;

    rle_state_t        w_state_nxt;
    logic [DATA_W-1:0] w_sym_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_emit;
    logic [DATA_W-1:0] w_emit_data;
    logic [CNT_W-1:0]  w_emit_cnt;
    logic              w_emit_last;
    logic              w_out_free;
    logic              w_accept;

    // Refuse input while flushing or while the pending pair cannot move on.
    assign din_ready = RST_N && (r_state != ST_FLUSH) && w_out_free;
    assign w_accept  = din_valid && din_ready;

    // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_sym_nxt   = r_run_sym;
        w_cnt_nxt   = r_run_cnt;
        w_emit      = 1'b0;
        w_emit_data = r_run_sym;
        w_emit_cnt  = r_run_cnt;
        w_emit_last = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_sym_nxt = din;
                    w_cnt_nxt = CNT_ONE;
                    if (din_last) begin
                        w_emit      = 1'b1;
                        w_emit_data = din;
                        w_emit_cnt  = CNT_ONE;
                        w_emit_last = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (w_accept) begin
                    if ((din == r_run_sym) && (r_run_cnt < MAX_RUN)) begin
                        w_cnt_nxt = r_run_cnt + CNT_ONE;
                        if (din_last) begin
                            w_emit      = 1'b1;
                            w_emit_cnt  = r_run_cnt + CNT_ONE;
                            w_emit_last = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        // New symbol or saturated count: close the current run, open a run of 1.
                        w_emit    = 1'b1;
                        w_sym_nxt = din;
                        w_cnt_nxt = CNT_ONE;
                        if (din_last) begin
                            w_state_nxt = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (w_out_free) begin
                    w_emit      = 1'b1;
                    w_emit_cnt  = CNT_ONE;
                    w_emit_last = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= ST_IDLE;
            r_run_sym <= '0;
            r_run_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_run_sym <= w_sym_nxt;
            r_run_cnt <= w_cnt_nxt;
        end
    end

    rle_out_reg #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) u_out_reg (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .i_load  (w_emit),
        .i_data  (w_emit_data),
        .i_cnt   (w_emit_cnt),
        .i_last  (w_emit_last),
        .i_ready (dout_ready),
        .o_valid (dout_valid),
        .o_data  (data_dout),
        .o_cnt   (data_cout),
        .o_last  (dout_last),
        .o_free  (w_out_free)
    );

`ifdef RLE_STATS_EN
    logic [15:0] r_stat_bytes;
    logic [15:0] r_stat_pairs;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stat_bytes <= '0;
            r_stat_pairs <= '0;
        end else begin
            if (w_accept) begin
                r_stat_bytes <= r_stat_bytes + 16'd1;
            end
            if (dout_valid && dout_ready) begin
                r_stat_pairs <= r_stat_pairs + 16'd1;
            end
        end
    end

    assign stat_bytes = r_stat_bytes;
    assign stat_pairs = r_stat_pairs;
`endif

endmodule

// File: tb/tb_run_length_encoder.sv
// Self-checking bench for run_length_encoder: cycle-exact vector table, corner-case
// sequences, and random messages scored against a run-splitting reference model.
module tb_run_length_encoder;

    typedef struct packed {
        logic [7:0] sym;
        logic [3:0] cnt;
        logic       last;
    } pair_t;

    typedef struct {
        logic [7:0] din;
        logic       last;
        logic       emit;
        logic [7:0] sym;
        logic [3:0] cnt;
        logic       elast;
    } vec_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] din = '0;
    logic       din_last = 1'b0;
    logic       din_ready;
    logic       dout_valid;
    logic [7:0] data_dout;
    logic [3:0] data_cout;
    logic       dout_last;
    logic       dout_ready = 1'b0;
`ifdef RLE_STATS_EN
    logic [15:0] stat_bytes;
    logic [15:0] stat_pairs;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int tb_bytes = 0;
    int tb_pairs = 0;

    pair_t      got_q[$];
    pair_t      exp_q[$];
    logic [7:0] msg_q[$];
    vec_t       tbl[$];
    bit         prev_stall = 1'b0;
    pair_t      prev_pair;

    run_length_encoder #(.DATA_W(8), .CNT_W(4)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .din_valid  (din_valid),
        .din        (din),
        .din_last   (din_last),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .data_dout  (data_dout),
        .data_cout  (data_cout),
        .dout_last  (dout_last),
        .dout_ready (dout_ready)
`ifdef RLE_STATS_EN
       ,.stat_bytes (stat_bytes),
        .stat_pairs (stat_pairs)
`endif
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 unit later, record transfers.
    task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic r,
                         output logic acc);
        pair_t cur;
        @(negedge CLK);
        din_valid  = v;
        din        = d;
        din_last   = l;
        dout_ready = r;
        #1;
        cur = '{sym: data_dout, cnt: data_cout, last: dout_last};
        if (prev_stall) begin
            check("stall_valid_hold", 32'(dout_valid), 32'd1);
            check("stall_pair_hold", 32'(cur), 32'(prev_pair));
        end
        if (dout_valid && !dout_ready) check("stall_blocks_input", 32'(din_ready), 32'd0);
        if (dout_valid) check("count_nonzero", 32'(data_cout != 4'd0), 32'd1);
        acc = v && din_ready;
        if (acc) tb_bytes++;
        if (dout_valid && dout_ready) begin
            got_q.push_back(cur);
            tb_pairs++;
        end
        prev_stall = dout_valid && !dout_ready;
        prev_pair  = cur;
    endtask

    task automatic drain(input int n);
        logic acc;
        int   guard = 0;
        while (got_q.size() < n && guard < 200) begin
            cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
            guard++;
        end
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
    endtask

    task automatic compare_pairs(input string name);
        int n;
        check({name, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) check({name, "_pair"}, 32'(got_q[k]), 32'(exp_q[k]));
        got_q.delete();
    endtask

    // Reference: split each maximal run of equal bytes into chunks of at most 15.
    task automatic build_expected();
        int    i = 0;
        pair_t p;
        exp_q.delete();
        while (i < msg_q.size()) begin
            logic [7:0] s = msg_q[i];
            int         len = 0;
            while (i < msg_q.size() && msg_q[i] == s) begin
                len++;
                i++;
            end
            while (len > 0) begin
                int c = (len > 15) ? 15 : len;
                exp_q.push_back('{sym: s, cnt: 4'(c), last: 1'b0});
                len -= c;
            end
        end
        p = exp_q.pop_back();
        p.last = 1'b1;
        exp_q.push_back(p);
    endtask

    task automatic run_msg(input int pv, input int pr);
        logic acc;
        int   i = 0;
        int   guard = 0;
        while (i < msg_q.size() && guard < 4000) begin
            logic v = ($urandom_range(99) < pv);
            logic r = ($urandom_range(99) < pr);
            cycle(v, msg_q[i], (i == msg_q.size() - 1), r, acc);
            if (acc) i++;
            guard++;
        end
        check("send_budget", i, msg_q.size());
        drain(exp_q.size());
    endtask

    task automatic add(input logic [7:0] d, input logic l, input logic e,
                       input logic [7:0] s, input logic [3:0] c, input logic el);
        vec_t t;
        t = '{din: d, last: l, emit: e, sym: s, cnt: c, elast: el};
        tbl.push_back(t);
    endtask

    initial begin
        logic acc;

        // Reset state
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        #3;
        check("rst_din_ready", 32'(din_ready), 32'd0);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_fields", {19'd0, data_dout, data_cout, dout_last}, 32'd0);
        din_valid = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;

        // Cycle-exact table: pair visible one cycle after the closing byte.
        add(8'd100, 0, 0, 0, 0, 0);
        add(8'd100, 0, 0, 0, 0, 0);
        add(8'd97,  0, 1, 8'd100, 4'd2, 0);
        add(8'd97,  0, 0, 0, 0, 0);
        add(8'd97,  0, 0, 0, 0, 0);
        add(8'd98,  0, 1, 8'd97, 4'd3, 0);
        add(8'd98,  0, 0, 0, 0, 0);
        add(8'd99,  0, 1, 8'd98, 4'd2, 0);
        add(8'd99,  0, 0, 0, 0, 0);
        add(8'd99,  0, 0, 0, 0, 0);
        add(8'd99,  1, 1, 8'd99, 4'd4, 1);
        for (int k = 0; k < 15; k++) add(8'h41, 0, 0, 0, 0, 0);
        add(8'h41, 0, 1, 8'h41, 4'd15, 0);
        add(8'h41, 1, 1, 8'h41, 4'd2, 1);
        add(8'h55, 1, 1, 8'h55, 4'd1, 1);
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(1'b1, tbl[i].din, tbl[i].last, 1'b1, acc);
            check("tbl_accept", 32'(acc), 32'd1);
            @(posedge CLK);
            #1;
            check("tbl_valid", 32'(dout_valid), 32'(tbl[i].emit));
            if (tbl[i].emit)
                check("tbl_pair", {19'd0, data_dout, data_cout, dout_last},
                      {19'd0, tbl[i].sym, tbl[i].cnt, tbl[i].elast});
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        check("tbl_idle_after", 32'(dout_valid), 32'd0);
        got_q.delete();

        // 7,7,9(last): FLUSH blocks input, then emits the trailing run of 1.
        cycle(1'b1, 8'd7, 1'b0, 1'b1, acc);
        cycle(1'b1, 8'd7, 1'b0, 1'b1, acc);
        cycle(1'b1, 8'd9, 1'b1, 1'b1, acc);
        cycle(1'b1, 8'h77, 1'b0, 1'b1, acc);
        check("flush_blocks_input", 32'(acc), 32'd0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, acc);
        check("flush_ready_again", 32'(din_ready), 32'd1);
        drain(2);
        exp_q.delete();
        exp_q.push_back('{sym: 8'd7, cnt: 4'd2, last: 1'b0});
        exp_q.push_back('{sym: 8'd9, cnt: 4'd1, last: 1'b1});
        compare_pairs("flush");

        // Consumer stall for 5 cycles mid-stream.
        cycle(1'b1, 8'd1, 1'b0, 1'b1, acc);
        cycle(1'b1, 8'd1, 1'b0, 1'b1, acc);
        cycle(1'b1, 8'd2, 1'b0, 1'b1, acc);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 8'd2, 1'b0, 1'b0, acc);
            check("stall_no_accept", 32'(acc), 32'd0);
        end
        cycle(1'b1, 8'd2, 1'b0, 1'b1, acc);
        check("stall_resume_accept", 32'(acc), 32'd1);
        cycle(1'b1, 8'd3, 1'b1, 1'b1, acc);
        drain(3);
        exp_q.delete();
        exp_q.push_back('{sym: 8'd1, cnt: 4'd2, last: 1'b0});
        exp_q.push_back('{sym: 8'd2, cnt: 4'd2, last: 1'b0});
        exp_q.push_back('{sym: 8'd3, cnt: 4'd1, last: 1'b1});
        compare_pairs("stall");

        // Reset mid-run with a pending pair held by a stalled consumer.
        cycle(1'b1, 8'd8, 1'b0, 1'b1, acc);
        cycle(1'b1, 8'd4, 1'b0, 1'b1, acc);
        cycle(1'b1, 8'd4, 1'b0, 1'b0, acc);
        cycle(1'b1, 8'd4, 1'b0, 1'b0, acc);
        check("pre_reset_pending", 32'(dout_valid), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        check("midrst_dout_valid", 32'(dout_valid), 32'd0);
        check("midrst_fields", {19'd0, data_dout, data_cout, dout_last}, 32'd0);
        check("midrst_din_ready", 32'(din_ready), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N      = 1'b1;
        din_valid  = 1'b0;
        got_q.delete();
        prev_stall = 1'b0;
        tb_bytes   = 0;
        tb_pairs   = 0;
        msg_q.delete();
        msg_q.push_back(8'd3);
        msg_q.push_back(8'd3);
        build_expected();
        run_msg(100, 100);
        compare_pairs("post_reset");

        // Random messages against the reference model.
        for (int m = 0; m < 30; m++) begin
            int target = $urandom_range(60, 1);
            msg_q.delete();
            while (msg_q.size() < target) begin
                logic [7:0] s  = 8'($urandom_range(3));
                int         rl = ($urandom_range(3) == 0) ? $urandom_range(40, 10) : $urandom_range(4, 1);
                for (int k = 0; k < rl && msg_q.size() < target; k++) msg_q.push_back(s);
            end
            build_expected();
            run_msg(80, 60);
            compare_pairs("random");
        end

`ifdef RLE_STATS_EN
        check("stat_bytes", 32'(stat_bytes), 32'(tb_bytes[15:0]));
        check("stat_pairs", 32'(stat_pairs), 32'(tb_pairs[15:0]));
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
